// File: rtl/bnn_binarize_pack_pkg.sv
// Shared BNN constants and types: default activation/popcount widths,
// the comparison-sense encoding and the packer controller states.
package bnn_pkg;

  localparam int BNN_ACT_WIDTH = 128;
  localparam int BNN_CNT_W     = 8;

  typedef logic [BNN_CNT_W-1:0] bnn_cnt_t;

  // GE is the normal batch-norm case, LE is used when the folded scale is negative
  typedef enum logic {
    GE = 1'b0,
    LE = 1'b1
  } bnn_cmp_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } bnn_pack_state_e;

endpackage

// File: rtl/bnn_binarize_pack_if.sv
// Popcount-in / packed-word-out stream bundle for the binarize-and-pack stage.
interface bnn_binarize_pack_if
  import bnn_pkg::*;
#(
  parameter int WIDTH = BNN_ACT_WIDTH,
  parameter int CNT_W = BNN_CNT_W,
  parameter int NB_W  = $clog2(WIDTH) + 1
);

  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] in_thresh;
  logic             in_neg;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [NB_W-1:0]  out_nbits;

  modport master (
    output in_valid, in_cnt, in_thresh, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_nbits
  );

  modport slave (
    input  in_valid, in_cnt, in_thresh, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_word, out_nbits
  );

endinterface

// File: rtl/bnn_binarize_pack_threshold.sv
// Combinational binarization of one popcount against its neuron threshold.
module bnn_threshold
  import bnn_pkg::*;
#(
  parameter int CNT_W = BNN_CNT_W
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic             i_neg,
  output logic             o_bit
);

  bnn_cmp_e w_sense;

  assign w_sense = bnn_cmp_e'(i_neg);

  // Equality maps to 1 in both senses
  always_comb begin
    o_bit = 1'b0;
    case (w_sense)
      GE:      o_bit = (i_cnt >= i_thresh);
      LE:      o_bit = (i_cnt <= i_thresh);
      default: o_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/bnn_binarize_pack.sv
// Binarizes one popcount per cycle and packs the bits LSB-first into
// WIDTH-bit activation words, flushing early on in_last.
module bnn_binarize_pack
  import bnn_pkg::*;
#(
  parameter int WIDTH = BNN_ACT_WIDTH,
  parameter int CNT_W = BNN_CNT_W,
  parameter int NB_W  = $clog2(WIDTH) + 1
) (
  input logic                clk,
  input logic                rst,
  bnn_binarize_pack_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  function automatic logic [NB_W-1:0] f_nbits(input logic [IDX_W-1:0] idx);
    return NB_W'(idx) + NB_W'(1);
  endfunction

  bnn_pack_state_e  r_state;
  bnn_pack_state_e  w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_word;
  logic [NB_W-1:0]  r_nbits;

  logic             w_bit;
  logic             w_fire;
  logic             w_done;
  logic [WIDTH-1:0] w_acc_ins;
  logic [WIDTH-1:0] w_keep;

  bnn_threshold #(
    .CNT_W (CNT_W)
  ) u_threshold (
    .i_cnt    (bus.in_cnt),
    .i_thresh (bus.in_thresh),
    .i_neg    (bus.in_neg),
    .o_bit    (w_bit)
  );

  // A held word only blocks input while downstream is stalled
  assign bus.in_ready = (r_state == ST_EMPTY) || bus.out_ready;
  assign w_fire       = bus.in_valid && bus.in_ready;
  assign w_done       = w_fire && ((r_idx == LAST_IDX) || bus.in_last);

  always_comb begin
    w_acc_ins        = r_acc;
    w_acc_ins[r_idx] = w_bit;
  end

  // Bits above the current index are forced to zero so padding is always clean
  assign w_keep = {WIDTH{1'b1}} >> (LAST_IDX - r_idx);

  // ---- controller: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- controller: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_done) w_state_nxt = ST_FULL;
      ST_FULL:  if (bus.out_ready && !w_done) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // ---- controller: outputs ----
  always_comb begin
    bus.out_valid = 1'b0;
    if (r_state == ST_FULL) bus.out_valid = 1'b1;
  end

  // ---- packing stage: index counter and accumulator ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_done) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_fire) begin
      r_idx <= r_idx + IDX_W'(1);
      r_acc <= w_acc_ins;
    end
  end

  // ---- output stage: completed word register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_nbits <= '0;
    end else if (w_done) begin
      r_word  <= w_acc_ins & w_keep;
      r_nbits <= f_nbits(r_idx);
    end
  end

  assign bus.out_word  = r_word;
  assign bus.out_nbits = r_nbits;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_word) && $stable(bus.out_nbits)));

  a_nbits_nonzero: assert property (@(posedge clk) disable iff (rst)
    bus.out_valid |-> (bus.out_nbits != '0));

endmodule

// File: tb/tb_bnn_binarize_pack.sv
// Bench for bnn_binarize_pack: compare-sense table, full/partial words,
// backpressure, back-to-back words and reset behaviour.
module tb_bnn_binarize_pack;
  import bnn_pkg::*;

  localparam int WIDTH = 128;
  localparam int CNT_W = 8;
  localparam int NB_W  = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bnn_binarize_pack_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .NB_W(NB_W)) bus ();

  bnn_binarize_pack #(.WIDTH(WIDTH), .CNT_W(CNT_W), .NB_W(NB_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [NB_W-1:0]  nbits;
  } exp_t;

  typedef struct {
    bnn_cnt_t cnt;
    bnn_cnt_t th;
    logic     neg;
    logic     exp_bit;
  } vec_t;

  exp_t sb[$];
  int   vcyc[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   ov_cycles = 0;
  int   last_acc_cyc = 0;

  bit               model_en = 1'b0;
  int               m_idx = 0;
  logic [WIDTH-1:0] m_acc = '0;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every popped word is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        ov_cycles++;
        vcyc.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) fail_now("spurious_word");
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_word", bus.out_word, e.word);
          chk("out_nbits", WIDTH'(bus.out_nbits), WIDTH'(e.nbits));
        end
      end
    end
  end

  task automatic model_accept(input bnn_cnt_t c, input bnn_cnt_t t, input logic n, input logic l);
    logic b;
    exp_t e;
    b = n ? (c <= t) : (c >= t);
    m_acc[m_idx] = b;
    if (m_idx == WIDTH - 1 || l) begin
      e.word  = m_acc;
      e.nbits = NB_W'(m_idx + 1);
      sb.push_back(e);
      m_idx = 0;
      m_acc = '0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] w, input int nb);
    exp_t e;
    e.word  = w;
    e.nbits = NB_W'(nb);
    sb.push_back(e);
  endtask

  task automatic send_beat(input bnn_cnt_t c, input bnn_cnt_t t, input logic n, input logic l);
    int waits;
    waits = 0;
    bus.in_valid  = 1'b1;
    bus.in_cnt    = c;
    bus.in_thresh = t;
    bus.in_neg    = n;
    bus.in_last   = l;
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) fail_now("beat_accept_timeout");
    else begin
      last_acc_cyc = cyc;
      if (model_en) model_accept(c, t, n, l);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vt[9];
  int   t0;

  initial begin
    vt[0] = '{8'd10,  8'd10,  1'b0, 1'b1};
    vt[1] = '{8'd10,  8'd10,  1'b1, 1'b1};
    vt[2] = '{8'd11,  8'd10,  1'b1, 1'b0};
    vt[3] = '{8'd255, 8'd0,   1'b0, 1'b1};
    vt[4] = '{8'd9,   8'd10,  1'b0, 1'b0};
    vt[5] = '{8'd0,   8'd0,   1'b1, 1'b1};
    vt[6] = '{8'd0,   8'd255, 1'b1, 1'b1};
    vt[7] = '{8'd255, 8'd254, 1'b1, 1'b0};
    vt[8] = '{8'd0,   8'd1,   1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_cnt    = '0;
    bus.in_thresh = '0;
    bus.in_neg    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_out_valid", WIDTH'(bus.out_valid), '0);
    chk("rst_out_word", bus.out_word, '0);
    chk("rst_out_nbits", WIDTH'(bus.out_nbits), '0);
    chk("rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Compare-sense table: each vector flushes a one-bit word
    for (int i = 0; i < 9; i++) begin
      push_exp(WIDTH'(vt[i].exp_bit), 1);
      send_beat(vt[i].cnt, vt[i].th, vt[i].neg, 1'b1);
    end
    idle(3);

    // Full word, alternating threshold, in_last on the final slot
    ov_cycles = 0;
    push_exp({(WIDTH/4){4'h5}}, WIDTH);
    for (int i = 0; i < WIDTH; i++)
      send_beat(8'd64, (i % 2 == 0) ? 8'd64 : 8'd65, 1'b0, i == WIDTH - 1);
    idle(5);
    chk("full_word_valid_cycles", WIDTH'(ov_cycles), WIDTH'(1));

    // Partial flush, then the next word starts again at bit 0
    push_exp(WIDTH'(8'h1D), 5);
    send_beat(8'd5,   8'd3,   1'b0, 1'b0);
    send_beat(8'd2,   8'd3,   1'b0, 1'b0);
    send_beat(8'd3,   8'd3,   1'b0, 1'b0);
    send_beat(8'd0,   8'd7,   1'b1, 1'b0);
    send_beat(8'd200, 8'd100, 1'b0, 1'b1);
    push_exp(WIDTH'(2'b10), 2);
    send_beat(8'd1, 8'd2, 1'b0, 1'b0);
    send_beat(8'd2, 8'd2, 1'b1, 1'b1);
    idle(3);

    // Backpressure: a completed word is held while out_ready is low
    bus.out_ready = 1'b0;
    send_beat(8'd1, 8'd2, 1'b0, 1'b0);
    send_beat(8'd7, 8'd2, 1'b0, 1'b0);
    send_beat(8'd9, 8'd9, 1'b0, 1'b1);
    push_exp(WIDTH'(3'b110), 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 0) begin
        chk("bp_in_ready", WIDTH'(bus.in_ready), '0);
        chk("bp_out_valid", WIDTH'(bus.out_valid), WIDTH'(1));
        chk("bp_word", bus.out_word, WIDTH'(3'b110));
        chk("bp_nbits", WIDTH'(bus.out_nbits), WIDTH'(3));
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    idle(2);
    @(negedge clk);
    chk("bp_after_pop_valid", WIDTH'(bus.out_valid), '0);
    @(posedge clk); #1;

    // Back-to-back words: 256 continuous beats, pop and completion coincide
    model_en = 1'b1;
    vcyc.delete();
    for (int i = 0; i < 2 * WIDTH; i++) begin
      send_beat(bnn_cnt_t'($urandom_range(0, 255)), bnn_cnt_t'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'b0);
      if (i == 0) t0 = last_acc_cyc;
    end
    idle(4);
    chk("b2b_word_count", WIDTH'(vcyc.size()), WIDTH'(2));
    if (vcyc.size() >= 2) begin
      chk("b2b_first_cycle", WIDTH'(vcyc[0] - t0), WIDTH'(WIDTH));
      chk("b2b_second_cycle", WIDTH'(vcyc[1] - t0), WIDTH'(2 * WIDTH));
    end

    // Reset drops a held output word
    model_en = 1'b0;
    bus.out_ready = 1'b0;
    send_beat(8'd4, 8'd3, 1'b0, 1'b0);
    send_beat(8'd4, 8'd3, 1'b0, 1'b1);
    @(negedge clk);
    chk("held_before_rst", WIDTH'(bus.out_valid), WIDTH'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("held_rst_valid", WIDTH'(bus.out_valid), '0);
    chk("held_rst_word", bus.out_word, '0);
    chk("held_rst_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
    idle(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);

    // Reset mid-word discards the partial bits
    model_en = 1'b1;
    for (int i = 0; i < 40; i++) send_beat(8'd200, 8'd10, 1'b0, 1'b0);
    rst = 1'b1;
    m_idx = 0;
    m_acc = '0;
    #1;
    chk("midword_rst_nbits", WIDTH'(bus.out_nbits), '0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send_beat(8'd5, 8'd5, 1'b0, 1'b0);
    send_beat(8'd4, 8'd5, 1'b0, 1'b0);
    send_beat(8'd6, 8'd5, 1'b0, 1'b1);
    idle(4);
    model_en = 1'b0;

    chk("scoreboard_drained", WIDTH'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bnn_binarize_pack.md
# bnn_binarize_pack

Closes the loop around the XNOR-popcount datapath. Takes one popcount result per cycle, binarizes it against a per-neuron threshold, and packs the resulting activation bits LSB-first into WIDTH-bit words, which are the `xi` operands for the next layer's XNOR-popcount array. Sits between a layer's popcount/accumulate output and the activation buffer that feeds the next layer.

## Interface
- `WIDTH`, 128: activation bits per packed output word. Must be ≥ 2.
- `CNT_W`, 8: popcount / threshold width, unsigned. Matches the 128-input popcount result.
- `NB_W`, $clog2(WIDTH)+1: width of the valid-bit count.
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block can accept a beat this cycle.
- `in_cnt` input CNT_W: popcount for one neuron.
- `in_thresh` input CNT_W: threshold for that neuron.
- `in_neg` input 1: comparison sense. 0 selects ≥; 1 selects ≤, for a negative batch-norm scale.
- `in_last` input 1: this beat ends the current vector; flush the partial word.
- `out_valid` output 1: packed word available.
- `out_ready` input 1: downstream accepts the word.
- `out_word` output WIDTH: packed activations. Bit i is the i-th accepted beat of the word.
- `out_nbits` output NB_W: number of meaningful bits in `out_word`, range 1..WIDTH.

## Operation
- Accept: a beat transfers when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. It is combinational and must not depend on `in_valid`.
- Bit computation:
  - When `in_neg=0`: bit = (`in_cnt >= in_thresh`).
  - When `in_neg=1`: bit = (`in_cnt <= in_thresh`).
  - Both compares are unsigned, full CNT_W width. `in_cnt == in_thresh` gives 1 in both senses.
- Packing state:
  - Bit index `idx` runs 0..WIDTH-1. The accumulation register is `acc[WIDTH-1:0]`.
  - An accepted bit is written to `acc[idx]`.
- Word completes when the accepted beat has `idx == WIDTH-1` or `in_last=1`. On completion:
  - `out_word` ← `acc` with the new bit inserted, and bits above `idx` forced to 0.
  - `out_nbits` ← `idx+1`.
  - `out_valid` ← 1.
  - `idx` ← 0 and `acc` ← 0.
- Otherwise `idx` ← `idx+1`.
- Output hold: while `out_valid && !out_ready`, `out_word` and `out_nbits` are stable and `in_ready=0`.
- Output release: when `out_valid && out_ready` and no completion occurs this cycle, `out_valid` ← 0.
- Simultaneous pop and completion: `out_valid` stays 1 and the new word replaces the old one in the same edge. This gives one word per WIDTH cycles with no bubble.
- `in_last` with `idx==WIDTH-1` emits one full word (`out_nbits=WIDTH`). It must never produce a second, empty word.
- Padding bits (index ≥ `out_nbits`) are always 0. The next layer handles the padding correction.
- Two-state controller:
  - EMPTY (`out_valid=0`): moves to FULL on completion.
  - FULL (`out_valid=1`): moves to EMPTY on a pop without completion. Stays FULL on a pop with completion, or with no pop.

## Timing
- Reset values: `out_valid=0`, `out_word=0`, `out_nbits=0`, `idx=0`, `acc=0`. `in_ready=1` as soon as `rst` asserts.
- Reset mid-word discards partial bits. A held output word is dropped.
- Latency: `out_valid` rises on the clock edge that accepts the completing beat, so the word is visible the following cycle.
- Sustained throughput is one beat per cycle while `out_ready=1`.
- No combinational path from any input to `out_word`, `out_nbits` or `out_valid`.
- The only combinational path is `out_ready` → `in_ready`.

## Structure
- Shared package `bnn_pkg` holds:
  - `BNN_ACT_WIDTH` (128) and `BNN_CNT_W` (8) default constants.
  - typedef `bnn_cnt_t` (logic [BNN_CNT_W-1:0]).
  - the `bnn_cmp_e` enum (GE, LE) encoding `in_neg`.
- One sub-module, `bnn_threshold`, holds the combinational compare (`in_cnt`, `in_thresh`, `in_neg` → bit). It is reused by the future streaming-threshold unit.
- Packer, index counter and output register live in the top module.

## Test plan
- Full word, WIDTH=128, `out_ready=1`: 128 beats with `in_cnt=64`, `in_thresh` alternating 64/65, `in_neg=0`, `in_last` only on beat 127.
  - One word `out_word` = 128'h5555…5555, `out_nbits=128`, `out_valid` high for 1 cycle.
- Partial flush: 5 beats producing bits 1,0,1,1,1 with `in_last` on beat 5.
  - `out_word=128'h1D`, `out_nbits=5`. The next word starts at bit 0.
- Compare sense: `in_cnt=10`, `in_thresh=10`, both `in_neg` values → bit 1. `in_cnt=11`, `in_thresh=10`, `in_neg=1` → bit 0. `in_cnt=255`, `in_thresh=0`, `in_neg=0` → bit 1.
- Backpressure: `out_ready=0` after a completed word.
  - `in_ready=0` and the word is stable for 20 cycles.
  - Raising `out_ready` pops the word and `in_ready` returns to 1 in the same cycle.
- Back-to-back words: 256 continuous beats with `out_ready=1`.
  - Exactly two words, with `out_valid` high on cycles 128 and 256 after the first accept.
  - No lost beat when a pop and a completion coincide.
- Reset mid-word: assert `rst` after 40 beats, then send 3 beats with `in_last`.
  - `out_nbits=3`. Bits 3..127 are 0.
